// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the dual-clock FIFO (Gray/binary conversion, pointer type).
// Latency: combinational functions only.
// Backpressure: none; pure definitions.
package fifo_pkg;

  // Address width of the default FIFO build; pointers carry one extra wrap bit.
  localparam int FIFO_ADDR_W = 4;
  // Conversion functions work on a fixed wide vector; callers cast to their pointer width.
  localparam int GRAY_W = 32;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Output-stage states used when the first-word-fall-through mode is built in.
  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_FETCH = 2'd1,
    OUT_VALID = 2'd2
  } out_state_t;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_sync.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into the local clock; flops reset to 0.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; samples d every cycle.
module cdc_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the incoming bus through the flop chain; asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer controller of the dual-clock FIFO: read pointer, write-pointer sync, status, read strobe.
// Latency: data one cycle after mem_rd_en; writes visible SYNC_STAGES+1 edges after write_ptr_gray changes.
// Backpressure: pops only while data is present; a pop on empty raises underflow. FWFT output stage via FIFO_FWFT_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic              read_clk,
  input  logic              read_rst,
  input  logic              read_enable,
  input  logic [ADDR_W:0]   write_ptr_gray,
  output logic [ADDR_W:0]   read_ptr_gray,
  output logic [ADDR_W-1:0] read_addr,
  output logic              mem_rd_en,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] wptr_sync;
  logic [ADDR_W:0] wbin_sync;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] level_next;
  logic            mem_empty;
  logic            mem_empty_next;
  logic            rd_valid_next;

  cdc_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (read_clk),
    .rst (read_rst),
    .d   (write_ptr_gray),
    .q   (wptr_sync)
  );

  assign wbin_sync      = PW'(gray2bin(GRAY_W'(wptr_sync)));
  assign rbin_next      = rbin + PW'(mem_rd_en);
  assign rgray_next     = PW'(bin2gray(GRAY_W'(rbin_next)));
  // Comparing in Gray space against the synchronised pointer avoids a second conversion.
  assign mem_empty_next = (rgray_next == wptr_sync);
  assign read_addr      = rbin[ADDR_W-1:0];

`ifdef FIFO_FWFT_EN
  out_state_t state;

  // Fetch whenever the output stage is free or being acknowledged this cycle.
  assign mem_rd_en     = ~mem_empty & ((state == OUT_EMPTY) | read_enable);
  assign rd_valid_next = mem_rd_en | (rd_valid & ~read_enable);
  // The word held at the storage output still counts as available.
  assign level_next    = (wbin_sync - rbin_next) + PW'(rd_valid_next);
  assign empty         = ~rd_valid;

  // Output-stage FSM: tracks whether the storage output holds an unacknowledged word.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      state     <= OUT_EMPTY;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= read_enable & ~rd_valid;
      rd_valid  <= rd_valid_next;
      case (state)
        OUT_EMPTY: begin
          if (mem_rd_en) state <= OUT_FETCH;
        end
        OUT_FETCH, OUT_VALID: begin
          if (mem_rd_en)        state <= OUT_FETCH;
          else if (read_enable) state <= OUT_EMPTY;
          else                  state <= OUT_VALID;
        end
        default: state <= OUT_EMPTY;
      endcase
    end
  end
`else
  assign mem_rd_en     = read_enable & ~mem_empty;
  assign rd_valid_next = mem_rd_en;
  assign level_next    = wbin_sync - rbin_next;
  assign empty         = mem_empty;

  // Standard mode: valid follows the read strobe by one cycle, underflow flags pops on empty.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= rd_valid_next;
      underflow <= read_enable & mem_empty;
    end
  end
`endif

  // Pointer and status registers; pops and newly synchronised writes fold into one update.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      rbin          <= '0;
      read_ptr_gray <= '0;
      mem_empty     <= 1'b1;
      rd_level      <= '0;
      almost_empty  <= 1'b1;
    end else begin
      rbin          <= rbin_next;
      read_ptr_gray <= rgray_next;
      mem_empty     <= mem_empty_next;
      rd_level      <= level_next;
      almost_empty  <= (level_next <= PW'(AEMPTY_THRESH));
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl with a count-based reference model of the FIFO read side.
// Latency: model tracks the synchroniser delay as a list of sampled write counts.
// Backpressure: stimulus writer never exceeds 16 words in flight.
module tb_fifo_read_ctrl;

  localparam int S = 2;

  logic       read_clk = 1'b0;
  logic       read_rst = 1'b0;
  logic       read_enable = 1'b0;
  logic [4:0] write_ptr_gray = '0;
  logic [4:0] read_ptr_gray;
  logic [3:0] read_addr;
  logic       mem_rd_en;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_level;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  // reference model state: plain counts of words written / popped
  logic [4:0] m_wcnt, m_rcnt, m_level;
  logic [4:0] m_sync [S];
  logic       m_empty, m_aempty, m_uflow, m_valid, m_mre;
  logic       got_mre;
  logic [3:0] got_addr;

  fifo_read_ctrl #(.ADDR_W(4), .SYNC_STAGES(S), .AEMPTY_THRESH(2)) dut (
    .read_clk       (read_clk),
    .read_rst       (read_rst),
    .read_enable    (read_enable),
    .write_ptr_gray (write_ptr_gray),
    .read_ptr_gray  (read_ptr_gray),
    .read_addr      (read_addr),
    .mem_rd_en      (mem_rd_en),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .rd_level       (rd_level),
    .underflow      (underflow)
  );

  always #5 read_clk = ~read_clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic exp_empty();
`ifdef FIFO_FWFT_EN
    return !m_valid;
`else
    return m_empty;
`endif
  endfunction

  task automatic model_reset();
    m_wcnt = '0; m_rcnt = '0; m_level = '0;
    for (int i = 0; i < S; i++) m_sync[i] = '0;
    m_empty = 1'b1; m_aempty = 1'b1; m_uflow = 1'b0; m_valid = 1'b0; m_mre = 1'b0;
    write_ptr_gray = '0;
  endtask

  task automatic do_reset();
    @(negedge read_clk);
    read_rst = 1'b0;
    read_enable = 1'b0;
    model_reset();
    repeat (2) @(negedge read_clk);
    read_rst = 1'b1;
  endtask

  // One read_clk cycle: drive inputs at negedge, capture the strobe, advance the model at posedge.
  task automatic cycle(input logic ren, input logic wr);
    logic       old_empty, old_valid;
    logic [4:0] ws;
    @(negedge read_clk);
    read_enable = ren;
    if (wr) m_wcnt = m_wcnt + 5'd1;
    write_ptr_gray = to_gray(m_wcnt);
`ifdef FIFO_FWFT_EN
    m_mre = !m_empty && (!m_valid || ren);
`else
    m_mre = ren && !m_empty;
`endif
    #1;
    got_mre = mem_rd_en;
    got_addr = read_addr;
    @(posedge read_clk);
    old_empty = m_empty;
    old_valid = m_valid;
    ws = m_sync[S-1];
    if (m_mre) m_rcnt = m_rcnt + 5'd1;
    m_empty = (ws == m_rcnt);
`ifdef FIFO_FWFT_EN
    m_valid = m_mre || (old_valid && !ren);
    m_uflow = ren && !old_valid;
    m_level = ws - m_rcnt + {4'b0, m_valid};
`else
    m_valid = m_mre;
    m_uflow = ren && old_empty;
    m_level = ws - m_rcnt;
`endif
    m_aempty = (m_level <= 5'd2);
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = m_wcnt;
    #1;
  endtask

  task automatic test_reset();
    read_rst = 1'b0;
    read_enable = 1'b1;
    model_reset();
    repeat (2) @(negedge read_clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (rd_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", rd_level); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en got=%b exp=0", mem_rd_en); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
    checks++; if (read_ptr_gray !== 5'd0 || read_addr !== 4'd0) begin failures++; $display("FAIL reset_ptr gray=%b addr=%0d exp 0", read_ptr_gray, read_addr); end
    checks++; if (rd_valid !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags valid=%b uflow=%b exp 0", rd_valid, underflow); end
    @(negedge read_clk);
    read_rst = 1'b1;
    cycle(1'b1, 1'b0);
    checks++; if (got_mre !== 1'b0) begin failures++; $display("FAIL reset_pop_strobe got=%b exp=0", got_mre); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL reset_underflow got=%b exp=1", underflow); end
    cycle(1'b0, 1'b0);
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_first_write();
    do_reset();
    cycle(1'b0, 1'b1);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL first_write_edge1 empty=%b exp=1", empty); end
    cycle(1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL first_write_edge2 empty=%b exp=1", empty); end
    cycle(1'b0, 1'b0);
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL first_write_edge3 empty=%b exp=0", empty); end
    checks++; if (rd_level !== 5'd1) begin failures++; $display("FAIL first_write_level got=%0d exp=1", rd_level); end
    checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL first_write_aempty got=%b exp=1", almost_empty); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    repeat (16) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    checks++; if (rd_level !== 5'd16 || almost_empty !== 1'b0 || empty !== 1'b0) begin
      failures++; $display("FAIL fill_status level=%0d aempty=%b empty=%b exp 16/0/0", rd_level, almost_empty, empty);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0);
      checks++; if (got_mre !== 1'b1 || got_addr !== 4'(i)) begin
        failures++; $display("FAIL drain_pop%0d strobe=%b addr=%0d exp 1/%0d", i, got_mre, got_addr, i);
      end
    end
    checks++; if (empty !== 1'b1 || rd_level !== 5'd0) begin failures++; $display("FAIL drain_empty empty=%b level=%0d exp 1/0", empty, rd_level); end
    checks++; if (read_ptr_gray !== 5'b11000) begin failures++; $display("FAIL drain_gray got=%b exp=11000", read_ptr_gray); end
    cycle(1'b1, 1'b0);
    checks++; if (got_mre !== 1'b0 || underflow !== 1'b1) begin failures++; $display("FAIL drain_underflow strobe=%b uflow=%b exp 0/1", got_mre, underflow); end
  endtask

  task automatic test_random();
    logic [4:0] prev_gray;
    logic       ren, wr;
    prev_gray = read_ptr_gray;
    for (int n = 0; n < 150; n++) begin
      ren = ($urandom_range(0, 99) < 60);
      wr  = ($urandom_range(0, 99) < 55) && ((m_wcnt - m_rcnt) < 5'd16);
      cycle(ren, wr);
      checks++; if (got_mre !== m_mre) begin failures++; $display("FAIL rnd%0d mem_rd_en got=%b exp=%b", n, got_mre, m_mre); end
      checks++; if (read_addr !== m_rcnt[3:0] || read_ptr_gray !== to_gray(m_rcnt)) begin
        failures++; $display("FAIL rnd%0d ptr addr=%0d gray=%b exp %0d/%b", n, read_addr, read_ptr_gray, m_rcnt[3:0], to_gray(m_rcnt));
      end
      checks++; if ($countones(prev_gray ^ read_ptr_gray) > 1) begin
        failures++; $display("FAIL rnd%0d gray_step prev=%b now=%b", n, prev_gray, read_ptr_gray);
      end
      checks++; if (empty !== exp_empty() || rd_level !== m_level || almost_empty !== m_aempty) begin
        failures++; $display("FAIL rnd%0d status empty=%b level=%0d aempty=%b exp %b/%0d/%b", n, empty, rd_level, almost_empty, exp_empty(), m_level, m_aempty);
      end
      checks++; if (rd_valid !== m_valid || underflow !== m_uflow) begin
        failures++; $display("FAIL rnd%0d flags valid=%b uflow=%b exp %b/%b", n, rd_valid, underflow, m_valid, m_uflow);
      end
      prev_gray = read_ptr_gray;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (10) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    checks++; if (rd_level !== m_level) begin failures++; $display("FAIL mid_level got=%0d exp=%0d", rd_level, m_level); end
    @(negedge read_clk);
    read_enable = 1'b1;
    read_rst = 1'b0;
    #1;
    checks++; if (read_addr !== 4'd0 || read_ptr_gray !== 5'd0 || rd_level !== 5'd0) begin
      failures++; $display("FAIL mid_reset_ptr addr=%0d gray=%b level=%0d exp 0", read_addr, read_ptr_gray, rd_level);
    end
    checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || rd_valid !== 1'b0 || underflow !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++; $display("FAIL mid_reset_flags empty=%b aempty=%b valid=%b uflow=%b strobe=%b exp 1/1/0/0/0",
                           empty, almost_empty, rd_valid, underflow, mem_rd_en);
    end
    model_reset();
    @(negedge read_clk);
    read_enable = 1'b0;
    read_rst = 1'b1;
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    do_reset();
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1 || empty !== 1'b0 || rd_level !== 5'd1) begin
      failures++; $display("FAIL fwft_fall valid=%b empty=%b level=%0d exp 1/0/1", rd_valid, empty, rd_level);
    end
    cycle(1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1 || underflow !== 1'b0) begin
      failures++; $display("FAIL fwft_pop valid=%b empty=%b uflow=%b exp 0/1/0", rd_valid, empty, underflow);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`else
    test_first_write();
    test_fill_drain();
`endif
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
